pipeline_hazard_sched: RTL

- Sequencing controller for the 5-stage processor pipeline (fetch, decode, execute, memory, writeback).
- Decides every cycle which stage registers advance, freeze, or take a bubble, covering:
  - load-use stalls;
  - taken-branch flushes;
  - data-memory wait states;
  - program halt.
- Sits beside the forwarding/hazard mux controller and drives the enable/flush inputs of stages 1–4.
- Also keeps saturating stall/flush performance counters.

---
 rtl/pipeline_hazard_sched_pkg.sv | 38 +++
 rtl/pipeline_hazard_sched_sat_counter.sv | 23 ++
 rtl/pipeline_hazard_sched.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_sched_pkg.sv
// Shared definitions for the pipeline sequencing controller: state
// encoding and the per-cycle stage control word.
package pipeline_hazard_sched_pkg;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    LDSTALL = 3'd1,
    FLUSH   = 3'd2,
    MEMWAIT = 3'd3,
    HALT    = 3'd4
  } sched_state_t;

  // One bit per stage-register control; order matches the port list.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_bubble;
    logic exmem_en;
  } stage_ctrl_t;

  // NOP control word: nothing advances, front-end registers load NOPs.
  localparam stage_ctrl_t CTRL_NOP    = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1,
                                          idex_bubble: 1'b1, exmem_en: 1'b0};
  // Normal flow: every stage advances.
  localparam stage_ctrl_t CTRL_RUN    = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0,
                                          idex_bubble: 1'b0, exmem_en: 1'b1};
  // Full freeze: nothing moves, nothing is squashed.
  localparam stage_ctrl_t CTRL_FREEZE = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                          idex_bubble: 1'b0, exmem_en: 1'b0};
  // Branch squash: PC loads target, fetch/decode slots become NOPs.
  localparam stage_ctrl_t CTRL_FLUSH  = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1,
                                          idex_bubble: 1'b1, exmem_en: 1'b1};
  // Load-use stall: front-end holds, a bubble enters execute, back-end drains.
  localparam stage_ctrl_t CTRL_STALL  = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                          idex_bubble: 1'b1, exmem_en: 1'b1};

endpackage

// File: rtl/pipeline_hazard_sched_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  // Count up on inc, stick at all-ones, synchronous clear wins over inc.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {WIDTH{1'b1}})) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_sched.sv
// Per-cycle sequencing controller for the 5-stage pipeline: decides which
// stage registers advance, freeze or take a bubble for load-use stalls,
// taken-branch flushes, data-memory wait states and halt.
//
// Data-memory handshake: dmem_req is high while the memory stage has an
// access in flight; dmem_ack is high in the single cycle the access
// completes. A cycle with dmem_req=1 and dmem_ack=0 is a wait cycle and
// freezes the whole pipeline; the ack cycle itself is a normal cycle.
module pipeline_hazard_sched
  import pipeline_hazard_sched_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 4,
  parameter int LOAD_STALL     = 1,
  parameter int FLUSH_CYCLES   = 2,
  parameter int MEM_TIMEOUT    = 255,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      RST,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs_a,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs_b,
  input  logic                      id_use_a,
  input  logic                      id_use_b,
  input  logic                      ex_is_load,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      br_taken,
  input  logic                      dmem_req,
  input  logic                      dmem_ack,
  input  logic                      halt_commit,
  output logic                      pc_en,
  output logic                      ifid_en,
  output logic                      ifid_flush,
  output logic                      idex_bubble,
  output logic                      exmem_en,
  output logic                      halted,
  output logic                      mem_err,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt,
  output logic [2:0]                state_dbg
);

  localparam int                WCNT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX   = WCNT_W'(MEM_TIMEOUT);
  localparam logic [WCNT_W-1:0] WCNT_ONE   = WCNT_W'(1);
  localparam logic [2:0]        FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0]        STALL_INIT = 3'(LOAD_STALL - 1);

  sched_state_t      state;
  logic [2:0]        sub;
  logic [WCNT_W-1:0] wcnt;
  logic [WCNT_W-1:0] wcnt_inc;
  logic              err_q;
  logic              hit;
  logic              mem_wait;
  logic              stall_inc;
  logic              flush_inc;
  stage_ctrl_t       ctrl;

  assign hit = ex_is_load && (ex_rd != '0) &&
               ((id_use_a && (id_rs_a == ex_rd)) || (id_use_b && (id_rs_b == ex_rd)));
  assign mem_wait = dmem_req && !dmem_ack;
  assign wcnt_inc = (wcnt == WCNT_MAX) ? wcnt : wcnt + WCNT_ONE;

  // Control word: reset overrides; halt, memory waits (including an
  // un-acked MEMWAIT) freeze; then flush/stall sequences; then new events.
  always_comb begin
    ctrl      = CTRL_RUN;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (!RST) begin
      ctrl = CTRL_NOP;
    end else if ((state == HALT) || halt_commit || mem_wait ||
                 ((state == MEMWAIT) && !dmem_ack)) begin
      ctrl = CTRL_FREEZE;
    end else if (state == FLUSH) begin
      ctrl = CTRL_FLUSH;
    end else if (state == LDSTALL) begin
      ctrl      = CTRL_STALL;
      stall_inc = 1'b1;
    end else if (br_taken) begin
      ctrl      = CTRL_FLUSH;
      flush_inc = 1'b1;
    end else if (hit) begin
      ctrl      = CTRL_STALL;
      stall_inc = 1'b1;
    end
  end

  // Sequencing FSM; an acked MEMWAIT cycle is evaluated exactly like RUN,
  // and a memory wait inside FLUSH/LDSTALL holds the sub-counter.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state <= RUN;
      sub   <= '0;
      wcnt  <= '0;
      err_q <= 1'b0;
    end else if (state != HALT) begin
      if (halt_commit) begin
        state <= HALT;
      end else begin
        case (state)
          RUN, MEMWAIT: begin
            if ((state == MEMWAIT) && !dmem_ack) begin
              wcnt <= wcnt_inc;
              if (wcnt_inc == WCNT_MAX) err_q <= 1'b1;
            end else if (mem_wait) begin
              state <= MEMWAIT;
              wcnt  <= WCNT_ONE;
              if (WCNT_ONE == WCNT_MAX) err_q <= 1'b1;
            end else if (br_taken) begin
              state <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
              sub   <= FLUSH_INIT;
            end else if (hit) begin
              state <= (LOAD_STALL > 1) ? LDSTALL : RUN;
              sub   <= STALL_INIT;
            end else begin
              state <= RUN;
            end
          end
          FLUSH, LDSTALL: begin
            if (!mem_wait) begin
              if (sub == 3'd1) state <= RUN;
              sub <= sub - 3'd1;
            end
          end
          default: state <= RUN;
        endcase
      end
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign ifid_en     = ctrl.ifid_en;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_bubble = ctrl.idex_bubble;
  assign exmem_en    = ctrl.exmem_en;
  assign halted      = RST && (state == HALT);
  assign mem_err     = err_q;
  assign state_dbg   = state;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk (clk),
    .RST (RST),
    .inc (stall_inc),
    .clr (1'b0),
    .q   (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk (clk),
    .RST (RST),
    .inc (flush_inc),
    .clr (1'b0),
    .q   (flush_cnt)
  );

endmodule
